// File: rtl/setup_sequencer.sv
// rtl/setup_sequencer.sv - time-setting controller: button debounce, setup-state ring, digit increment pulses
module setup_sequencer #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int TIMEOUT_CYCLES  = 500000000
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_mode_btn,
   input  logic       i_inc_btn,
   output logic [7:0] o_setup_time,
   output logic [5:0] o_inc_en,
   output logic       o_run
);

   localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   // State codes double as the one-hot LED indicator value.
   typedef enum logic [7:0] {
      ST_BASE   = 8'h01,
      ST_SEC1   = 8'h02,
      ST_SEC10  = 8'h04,
      ST_MIN1   = 8'h08,
      ST_MIN10  = 8'h10,
      ST_HOUR1  = 8'h20,
      ST_HOUR10 = 8'h40
   } state_t;

   // Index 0 is the MODE button, index 1 the INC button.
   logic [1:0]      w_raw;
   logic [1:0]      r_s1;
   logic [1:0]      r_s2;
   logic [1:0]      r_db;
   logic [1:0]      r_db_d;
   logic [DB_W-1:0] r_db_cnt [2];
   logic [1:0]      w_ev;
   logic            w_mode_ev;
   logic            w_inc_ev;

   state_t          r_state;
   state_t          w_next;
   state_t          w_ring_next;
   logic [5:0]      w_digit;
   logic            w_legal;
   logic [5:0]      w_inc_en;
   logic [5:0]      r_inc_en;
   logic            r_run;
   logic [TO_W-1:0] r_to_cnt;
   logic            w_expire;

   assign w_raw     = {i_inc_btn, i_mode_btn};
   assign w_ev      = r_db & ~r_db_d;
   assign w_mode_ev = w_ev[0];
   assign w_inc_ev  = w_ev[1];
   assign w_expire  = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   // Synchronize, debounce and delay both buttons; the level only moves after a full stable run.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_s1   <= '0;
         r_s2   <= '0;
         r_db   <= '0;
         r_db_d <= '0;
         for (int i = 0; i < 2; i++) r_db_cnt[i] <= '0;
      end else begin
         r_s1   <= w_raw;
         r_s2   <= r_s1;
         r_db_d <= r_db;
         for (int i = 0; i < 2; i++) begin
            if (r_s2[i] != r_db[i]) begin
               if (r_db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                  r_db[i]     <= r_s2[i];
                  r_db_cnt[i] <= '0;
               end else begin
                  r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
               end
            end else begin
               r_db_cnt[i] <= '0;
            end
         end
      end
   end

   // Next state and increment pulse: MODE beats INC, INC beats timeout, unknown codes fall back to BASE.
   always_comb begin
      w_next      = r_state;
      w_inc_en    = '0;
      w_ring_next = ST_BASE;
      w_digit     = '0;
      w_legal     = 1'b1;
      case (r_state)
         ST_BASE:   w_ring_next = ST_SEC1;
         ST_SEC1:   begin w_ring_next = ST_SEC10;  w_digit = 6'b000001; end
         ST_SEC10:  begin w_ring_next = ST_MIN1;   w_digit = 6'b000010; end
         ST_MIN1:   begin w_ring_next = ST_MIN10;  w_digit = 6'b000100; end
         ST_MIN10:  begin w_ring_next = ST_HOUR1;  w_digit = 6'b001000; end
         ST_HOUR1:  begin w_ring_next = ST_HOUR10; w_digit = 6'b010000; end
         ST_HOUR10: begin w_ring_next = ST_BASE;   w_digit = 6'b100000; end
         default:   w_legal = 1'b0;
      endcase
      if (!w_legal) begin
         w_next = ST_BASE;
      end else if (w_mode_ev) begin
         w_next = w_ring_next;
      end else if (r_state != ST_BASE) begin
         if (w_inc_ev) begin
            w_inc_en = w_digit;
         end else if (w_expire) begin
            w_next = ST_BASE;
         end
      end
   end

   // State, outputs and idle timer; the timer rests at 0 whenever BASE is next or an event occurs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= ST_BASE;
         r_inc_en <= '0;
         r_run    <= 1'b1;
         r_to_cnt <= '0;
      end else begin
         r_state  <= w_next;
         r_inc_en <= w_inc_en;
         r_run    <= (w_next == ST_BASE);
         if (w_mode_ev || w_inc_ev || (w_next == ST_BASE)) begin
            r_to_cnt <= '0;
         end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
         end
      end
   end

   assign o_setup_time = r_state;
   assign o_inc_en     = r_inc_en;
   assign o_run        = r_run;

endmodule

// File: tb/tb_setup_sequencer.sv
// tb/tb_setup_sequencer.sv - self-checking bench for setup_sequencer with an event-level reference model
module tb_setup_sequencer;

   localparam int DB = 4;
   localparam int TO = 50;
   localparam int LAT = DB + 3;

   logic       clk;
   logic       rst;
   logic       mode_btn;
   logic       inc_btn;
   logic [7:0] setup_time;
   logic [5:0] inc_en;
   logic       run;

   int         n_tests;
   int         n_fail;

   // Reference model: ring position 0..6 (0 = BASE), edges since last event, expected pulse.
   int         m_idx;
   int         m_idle;
   logic [5:0] m_inc;

   setup_sequencer #(
      .DEBOUNCE_CYCLES(DB),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_mode_btn  (mode_btn),
      .i_inc_btn   (inc_btn),
      .o_setup_time(setup_time),
      .o_inc_en    (inc_en),
      .o_run       (run)
   );

   always #5 clk = ~clk;

   // One clock edge: advance the model by the event that lands on this edge, then compare.
   task automatic step(input bit ev_mode, input bit ev_inc, input string nm);
      logic [14:0] exp_v;
      @(posedge clk);
      #1;
      m_inc = '0;
      if (ev_mode) begin
         m_idx  = (m_idx + 1) % 7;
         m_idle = 0;
      end else if (ev_inc) begin
         if (m_idx != 0) m_inc = 6'(1 << (m_idx - 1));
         m_idle = 0;
      end else if (m_idx != 0) begin
         m_idle++;
         if (m_idle == TO) begin
            m_idx  = 0;
            m_idle = 0;
         end
      end
      exp_v = {8'(1 << m_idx), m_inc, (m_idx == 0)};
      n_tests++;
      if ({setup_time, inc_en, run} !== exp_v) begin
         n_fail++;
         $display("FAIL %s t=%0t: got st=%h inc=%b run=%b, expected st=%h inc=%b run=%b",
                  nm, $time, setup_time, inc_en, run, exp_v[14:7], exp_v[6:1], exp_v[0]);
      end
   endtask

   // Hold the chosen raw button(s) high for hold edges; the event lands on the LAT-th edge.
   task automatic press(input bit pm, input bit pi, input int hold, input string nm);
      if (pm) mode_btn = 1'b1;
      if (pi) inc_btn = 1'b1;
      for (int k = 1; k <= hold; k++) step(pm && (k == LAT), pi && (k == LAT), nm);
      mode_btn = 1'b0;
      inc_btn  = 1'b0;
      for (int k = 0; k < DB + 4; k++) step(1'b0, 1'b0, nm);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      @(posedge clk);
      #1;
      n_tests++;
      if ({setup_time, inc_en, run} !== {8'h01, 6'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset: got st=%h inc=%b run=%b, expected st=01 inc=000000 run=1",
                  setup_time, inc_en, run);
      end
      rst = 1'b0;
      m_idx = 0; m_idle = 0; m_inc = '0;
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0, "reset_idle");
   endtask

   task automatic test_mode_ring;
      for (int p = 0; p < 7; p++) begin
         press(1'b1, 1'b0, $urandom_range(LAT + 1, LAT + 7), "mode_ring");
         repeat ($urandom_range(0, 5)) step(1'b0, 1'b0, "mode_ring_gap");
      end
   endtask

   task automatic test_base_inc_glitch;
      press(1'b0, 1'b1, $urandom_range(LAT + 1, LAT + 6), "base_inc");
      for (int g = 0; g < 4; g++) begin
         mode_btn = 1'b1;
         repeat ((g == 0) ? DB - 1 : $urandom_range(1, DB - 1)) step(1'b0, 1'b0, "mode_glitch");
         mode_btn = 1'b0;
         repeat (DB + 4) step(1'b0, 1'b0, "mode_glitch");
      end
   endtask

   task automatic test_coincident;
      press(1'b1, 1'b0, LAT + 1, "to_sec1");
      press(1'b1, 1'b0, LAT + 1, "to_sec10");
      press(1'b1, 1'b1, $urandom_range(LAT + 1, LAT + 5), "coincident");
   endtask

   task automatic test_inc_min1;
      press(1'b0, 1'b1, $urandom_range(LAT + 1, LAT + 5), "inc_min1_a");
      press(1'b0, 1'b1, $urandom_range(LAT + 1, LAT + 5), "inc_min1_b");
      press(1'b0, 1'b1, 100, "inc_min1_hold");
   endtask

   task automatic test_timeout;
      press(1'b1, 1'b0, LAT + 1, "timeout_enter");
      repeat (TO + 10) step(1'b0, 1'b0, "timeout_idle");
   endtask

   task automatic test_timeout_inc49;
      int wait_n;
      press(1'b1, 1'b0, LAT + 1, "t49_enter");
      wait_n = (TO - LAT) - m_idle;
      repeat (wait_n) step(1'b0, 1'b0, "t49_wait");
      press(1'b0, 1'b1, LAT + 1, "t49_inc");
      repeat (TO + 10) step(1'b0, 1'b0, "t49_restart");
   endtask

   task automatic test_reset_mid;
      for (int p = 0; p < 5; p++) press(1'b1, 1'b0, LAT + 1, "to_hour1");
      inc_btn = 1'b1;
      repeat (DB) step(1'b0, 1'b0, "rst_mid_debounce");
      #2;
      rst = 1'b1;
      #1;
      m_idx = 0; m_idle = 0; m_inc = '0;
      n_tests++;
      if ({setup_time, inc_en, run} !== {8'h01, 6'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_async: got st=%h inc=%b run=%b, expected st=01 inc=000000 run=1",
                  setup_time, inc_en, run);
      end
      inc_btn = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (12) step(1'b0, 1'b0, "rst_mid_quiet");
      press(1'b1, 1'b0, LAT + 1, "rst_mid_first_press");
   endtask

   initial begin
      clk      = 1'b0;
      rst      = 1'b1;
      mode_btn = 1'b0;
      inc_btn  = 1'b0;
      n_tests  = 0;
      n_fail   = 0;
      m_idx    = 0;
      m_idle   = 0;
      m_inc    = '0;
      test_reset();
      test_mode_ring();
      test_base_inc_glitch();
      test_coincident();
      test_inc_min1();
      test_timeout();
      test_timeout_inc49();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
